// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } state_t;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
  // Any non-BCD nibble decodes dark; this one is used for suppressed digits.
  localparam logic [BCD_W-1:0] BCD_DARK  = 4'hF;

endpackage

// File: rtl/seven_segment_display_decoder.sv
// BCD to 7-segment decoder, segments {a,b,c,d,e,f,g}, 1 = lit; non-BCD input is dark.
module seven_segment_display_decoder
  import seg_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (bcd)
      4'd0:    seg_c = 7'b1111110;
      4'd1:    seg_c = 7'b0110000;
      4'd2:    seg_c = 7'b1101101;
      4'd3:    seg_c = 7'b1111001;
      4'd4:    seg_c = 7'b0110011;
      4'd5:    seg_c = 7'b1011011;
      4'd6:    seg_c = 7'b1011111;
      4'd7:    seg_c = 7'b1110000;
      4'd8:    seg_c = 7'b1111111;
      4'd9:    seg_c = 7'b1111011;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexed N-digit 7-segment scan controller with blanking gaps and
// a double-buffered frame that only changes at frame boundaries.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        lz_suppress,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [BCD_W*NUM_DIGITS-1:0] load_data,
  output logic [SEG_W-1:0]            seg,
  output logic [NUM_DIGITS-1:0]       dig_en,
  output logic                        frame_done
);

  localparam int unsigned FRAME_W = BCD_W * NUM_DIGITS;
  localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [IDX_W-1:0]      index, index_n;
  logic [FRAME_W-1:0]    display, display_n;
  logic [FRAME_W-1:0]    pending, pending_n;
  logic                  pending_full, pending_full_n;
  logic [SEG_W-1:0]      seg_n;
  logic [NUM_DIGITS-1:0] dig_en_n;
  logic                  frame_done_n;
  logic                  load_ready_n;
  logic                  accept;
  logic                  commit;
  logic [BCD_W-1:0]      cur_nib;
  logic [BCD_W-1:0]      dec_in;
  logic                  lead_nz;
  logic                  suppress;
  logic [SEG_W-1:0]      dec_seg;

  // Select the current digit and find whether it or anything above it is non-zero.
  always_comb begin
    cur_nib = '0;
    lead_nz = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (index == IDX_W'(i)) cur_nib = display[i*BCD_W +: BCD_W];
      if ((index <= IDX_W'(i)) && (display[i*BCD_W +: BCD_W] != '0)) lead_nz = 1'b1;
    end
    suppress = lz_suppress && (index != '0) && !lead_nz;
    dec_in   = suppress ? BCD_DARK : cur_nib;
  end

  seven_segment_display_decoder u_dec (
    .bcd   (dec_in),
    .seg_c (dec_seg)
  );

  // Next-state, scan outputs and frame buffering.
  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    index_n        = index;
    seg_n          = seg;
    dig_en_n       = dig_en;
    frame_done_n   = 1'b0;
    display_n      = display;
    pending_n      = pending;
    pending_full_n = pending_full;
    accept         = load_valid && load_ready;
    commit         = (state == IDLE) && pending_full;

    if (!enable) begin
      state_n  = IDLE;
      cnt_n    = '0;
      index_n  = '0;
      seg_n    = SEG_BLANK;
      dig_en_n = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n  = BLANK;
          cnt_n    = '0;
          index_n  = '0;
          seg_n    = SEG_BLANK;
          dig_en_n = '0;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_n  = ON;
            cnt_n    = '0;
            dig_en_n = NUM_DIGITS'(1) << index;
            seg_n    = dec_seg;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        ON: begin
          if (cnt == DWELL_LAST) begin
            state_n  = BLANK;
            cnt_n    = '0;
            seg_n    = SEG_BLANK;
            dig_en_n = '0;
            if (index == IDX_LAST) begin
              index_n      = '0;
              frame_done_n = 1'b1;
              commit       = pending_full;
            end else begin
              index_n = index + IDX_W'(1);
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_n  = IDLE;
          cnt_n    = '0;
          index_n  = '0;
          seg_n    = SEG_BLANK;
          dig_en_n = '0;
        end
      endcase
    end

    // Accept and commit are mutually exclusive: accept needs an empty pending slot.
    if (commit) begin
      display_n      = pending;
      pending_full_n = 1'b0;
    end
    if (accept) begin
      pending_n      = load_data;
      pending_full_n = 1'b1;
    end
    load_ready_n = !pending_full_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      index        <= '0;
      display      <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      seg          <= SEG_BLANK;
      dig_en       <= '0;
      frame_done   <= 1'b0;
      load_ready   <= 1'b1;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      index        <= index_n;
      display      <= display_n;
      pending      <= pending_n;
      pending_full <= pending_full_n;
      seg          <= seg_n;
      dig_en       <= dig_en_n;
      frame_done   <= frame_done_n;
      load_ready   <= load_ready_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Self-checking bench for seg_scan_controller against a time-based reference model.
module tb_seg_scan_controller;

  localparam int N      = 4;
  localparam int D      = 8;
  localparam int B      = 2;
  localparam int SLOT   = B + D;
  localparam int PERIOD = N * SLOT;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        lz_suppress;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [6:0]  seg;
  logic [3:0]  dig_en;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  seg_scan_controller #(
    .NUM_DIGITS   (N),
    .DWELL_CYCLES (D),
    .BLANK_CYCLES (B)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .lz_suppress (lz_suppress),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .seg         (seg),
    .dig_en      (dig_en),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // Reference model: position within the frame is a plain cycle count since scanning began.
  bit          m_run   = 1'b0;
  int          m_t     = 0;
  logic [15:0] m_disp  = '0;
  logic [15:0] m_pend  = '0;
  bit          m_pfull = 1'b0;
  logic [6:0]  e_seg   = '0;
  logic [3:0]  e_dig   = '0;
  logic        e_fd    = 1'b0;
  logic        e_ready = 1'b1;
  bit          m_acc, m_com;
  int          m_slot, m_dg;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_run = 0; m_t = 0; m_disp = '0; m_pend = '0; m_pfull = 0;
      e_seg = '0; e_dig = '0; e_fd = 0; e_ready = 1;
    end else begin
      m_acc = load_valid && e_ready;
      m_com = 0;
      e_fd  = 0;
      if (!m_run) begin
        m_com = m_pfull;
        if (enable) begin m_run = 1; m_t = 0; end
        e_seg = '0; e_dig = '0;
      end else if (!enable) begin
        m_run = 0; m_t = 0; e_seg = '0; e_dig = '0;
      end else begin
        m_t++;
        if (m_t == PERIOD) begin m_t = 0; e_fd = 1; m_com = m_pfull; end
        m_slot = m_t % SLOT;
        m_dg   = m_t / SLOT;
        if (m_slot < B) begin
          e_seg = '0; e_dig = '0;
        end else if (m_slot == B) begin
          e_dig = 4'(1 << m_dg);
          if (lz_suppress && m_dg > 0 && (m_disp >> (m_dg * 4)) == 16'h0) e_seg = '0;
          else e_seg = seg_of(m_disp[m_dg*4 +: 4]);
        end
      end
      if (m_com) begin m_disp = m_pend; m_pfull = 0; end
      if (m_acc) begin m_pend = load_data; m_pfull = 1; end
      e_ready = !m_pfull;
    end
  end

  logic [12:0] obs, expv;
  assign obs  = {seg, dig_en, frame_done, load_ready};
  assign expv = {e_seg, e_dig, e_fd, e_ready};

  task automatic do_load(input logic [15:0] d);
    int k = 0;
    while (load_ready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    checks++;
    if (load_ready !== 1'b1) begin
      errors++; $display("FAIL load_wait: load_ready=%b expected 1", load_ready);
    end
    load_valid = 1'b1;
    load_data  = d;
    @(negedge clk);
    load_valid = 1'b0;
    load_data  = 16'($urandom);
  endtask

  task automatic wait_fd(output bit ok);
    ok = 0;
    for (int k = 0; k < 2 * PERIOD && !ok; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1) ok = 1;
    end
  endtask

  task automatic wait_lit(output bit ok);
    ok = 0;
    for (int k = 0; k < 2 * SLOT && !ok; k++) begin
      @(negedge clk);
      if (dig_en !== 4'b0000) ok = 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 0; enable = 1; lz_suppress = 0; load_valid = 0; load_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== {7'b0, 4'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL reset_values: got %b expected %b", obs, {7'b0, 4'b0, 1'b0, 1'b1});
    end
    rst_n = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (seg !== 7'b0 || dig_en !== 4'b0 || load_ready !== 1'b1) begin
        errors++; $display("FAIL reset_dark: seg=%b dig_en=%b rdy=%b expected 0/0/1", seg, dig_en, load_ready);
      end
    end
    @(negedge clk);
    checks++;
    if (dig_en !== 4'b0001 || seg !== 7'b1111110) begin
      errors++; $display("FAIL reset_first_on: dig_en=%b seg=%b expected 0001/1111110", dig_en, seg);
    end
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL reset_model: got %b expected %b", obs, expv); end
  endtask

  task automatic test_scan();
    int last_fd = -1;
    int fds = 0;
    logic [6:0] want;
    do_load(16'h1234);
    for (int c = 0; c < 2 * PERIOD + 2 * SLOT; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL scan cyc=%0d: got %b expected %b", cyc, obs, expv); end
      if (frame_done === 1'b1) begin
        if (last_fd >= 0) begin
          checks++;
          if (cyc - last_fd != PERIOD) begin
            errors++; $display("FAIL frame_period: got %0d expected %0d", cyc - last_fd, PERIOD);
          end
        end
        last_fd = cyc; fds++;
      end
      if (fds >= 1 && dig_en !== 4'b0000) begin
        case (dig_en)
          4'b0001: want = 7'b0110011;
          4'b0010: want = 7'b1111001;
          4'b0100: want = 7'b1101101;
          default: want = 7'b0110000;
        endcase
        checks++;
        if (seg !== want) begin
          errors++; $display("FAIL scan_1234 dig_en=%b: seg=%b expected %b", dig_en, seg, want);
        end
      end
    end
    checks++;
    if (fds < 2) begin errors++; $display("FAIL frame_done_count: got %0d expected >=2", fds); end
  endtask

  task automatic test_lz();
    bit ok;
    logic [6:0] want;
    lz_suppress = 1;
    for (int p = 0; p < 2; p++) begin
      do_load(p == 0 ? 16'h0042 : 16'h0000);
      wait_fd(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL lz_wait: no frame_done expected one"); end
      for (int c = 0; c < PERIOD; c++) begin
        @(negedge clk);
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL lz cyc=%0d: got %b expected %b", cyc, obs, expv); end
        case (dig_en)
          4'b0001: want = (p == 0) ? 7'b1101101 : 7'b1111110;
          4'b0010: want = (p == 0) ? 7'b0110011 : 7'b0000000;
          default: want = 7'b0000000;
        endcase
        if (dig_en !== 4'b0000) begin
          checks++;
          if (seg !== want) begin
            errors++; $display("FAIL lz_digit p=%0d dig_en=%b: seg=%b expected %b", p, dig_en, seg, want);
          end
        end
      end
    end
    lz_suppress = 0;
  endtask

  task automatic test_midframe();
    bit ok;
    int k;
    do_load(16'h1234);
    wait_fd(ok);
    k = 0;
    while (dig_en !== 4'b0100 && k < 2 * PERIOD) begin @(negedge clk); k++; end
    checks++;
    if (dig_en !== 4'b0100) begin errors++; $display("FAIL mid_wait: dig_en=%b expected 0100", dig_en); end
    do_load(16'h5678);
    checks++;
    if (load_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_drop: got %b expected 0", load_ready); end
    ok = 0;
    for (int c = 0; c < PERIOD && !ok; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL mid cyc=%0d: got %b expected %b", cyc, obs, expv); end
      if (frame_done === 1'b1) begin
        ok = 1;
        checks++;
        if (load_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_rise: got %b expected 1", load_ready); end
      end else begin
        checks++;
        if (load_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_hold: got %b expected 0", load_ready); end
        if (dig_en === 4'b0100 || dig_en === 4'b1000) begin
          checks++;
          if (seg !== (dig_en === 4'b0100 ? 7'b1101101 : 7'b0110000)) begin
            errors++; $display("FAIL mid_old_frame dig_en=%b: seg=%b", dig_en, seg);
          end
        end
      end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_commit: no frame_done expected one"); end
    wait_lit(ok);
    checks++;
    if (dig_en !== 4'b0001 || seg !== 7'b1111111) begin
      errors++; $display("FAIL mid_new_frame: dig_en=%b seg=%b expected 0001/1111111", dig_en, seg);
    end
  endtask

  task automatic test_invalid();
    bit ok;
    logic [6:0] want;
    do_load(16'h9A3B);
    wait_fd(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL inv_wait: no frame_done expected one"); end
    for (int c = 0; c < PERIOD; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL inv cyc=%0d: got %b expected %b", cyc, obs, expv); end
      case (dig_en)
        4'b0010: want = 7'b1111001;
        4'b1000: want = 7'b1111011;
        default: want = 7'b0000000;
      endcase
      if (dig_en !== 4'b0000) begin
        checks++;
        if (seg !== want) begin errors++; $display("FAIL inv_digit dig_en=%b: seg=%b expected %b", dig_en, seg, want); end
      end
    end
  endtask

  task automatic test_disable();
    bit ok;
    wait_lit(ok);
    enable = 0;
    @(negedge clk);
    checks++;
    if (seg !== 7'b0 || dig_en !== 4'b0) begin
      errors++; $display("FAIL disable_dark: seg=%b dig_en=%b expected 0/0", seg, dig_en);
    end
    repeat (3) @(negedge clk);
    enable = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL disable_model cyc=%0d: got %b expected %b", cyc, obs, expv); end
    end
    checks++;
    if (dig_en !== 4'b0001) begin errors++; $display("FAIL disable_restart: dig_en=%b expected 0001", dig_en); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_fd(ok);
    do_load(16'h4321);
    wait_lit(ok);
    checks++;
    if (load_ready !== 1'b0) begin errors++; $display("FAIL rmid_pending: load_ready=%b expected 0", load_ready); end
    rst_n = 0;
    @(negedge clk);
    checks++;
    if (seg !== 7'b0 || dig_en !== 4'b0 || load_ready !== 1'b1) begin
      errors++; $display("FAIL rmid_dark: seg=%b dig_en=%b rdy=%b expected 0/0/1", seg, dig_en, load_ready);
    end
    rst_n = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (dig_en !== 4'b0001 || seg !== 7'b1111110) begin
      errors++; $display("FAIL rmid_restart: dig_en=%b seg=%b expected 0001/1111110", dig_en, seg);
    end
    wait_fd(ok);
    wait_lit(ok);
    checks++;
    if (seg !== 7'b1111110) begin errors++; $display("FAIL rmid_discard: seg=%b expected 1111110", seg); end
  endtask

  task automatic test_random();
    int off = 0;
    logic [15:0] d;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL random cyc=%0d: got %b expected %b", cyc, obs, expv); end
      for (int i = 0; i < 4; i++) d[i*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      load_valid = ($urandom_range(0, 3) == 0);
      load_data  = d;
      if (c % 37 == 0) lz_suppress = 1'($urandom_range(0, 1));
      if (off > 0) off--;
      else if ($urandom_range(0, 149) == 0) off = $urandom_range(1, 5);
      enable = (off == 0);
    end
    load_valid = 0;
    enable = 1;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_lz();
    test_midframe();
    test_invalid();
    test_disable();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
